cover_toggle_collector: RTL and testbench
=========================================

COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 Parameter WIDTH, default 66: number of toggle cover points handled by this instance, 1..1024.
REQ-002 Parameter COVER_INDEX, default 0: global index of point 0; point i reports COVER_INDEX+i.
REQ-003 Parameter COVER_TOTAL, default 38253: total global cover points; COVER_INDEX+WIDTH SHALL be <= COVER_TOTAL, checked at elaboration.
REQ-004 Parameter DEPTH, default 4: report FIFO depth, power of two, >= 2.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 valid  input  WIDTH  per-point toggle-hit strobe, sampled every cycle.
REQ-008 enable  input  1  when low, valid is ignored.
REQ-009 clear  input  1  synchronous coverage clear, same effect as reset.
REQ-010 out_valid  output  1  report FIFO head is valid.
REQ-011 out_ready  input  1  consumer accepts head.
REQ-012 out_index  output  64  global index of head report.
REQ-013 hit_count  output  clog2(WIDTH+1)  number of distinct points hit since reset/clear.
REQ-014 all_covered  output  1  high iff hit_count == WIDTH.
REQ-015 busy  output  1  high iff any pending bit set or out_valid high.

Function
REQ-016 new_hits = valid & ~hit_map & {WIDTH{enable}}; only first hit of each point since reset/clear SHALL be reported.
REQ-017 At each edge, hit_map |= new_hits and pending |= new_hits; hit_count += popcount(new_hits), saturating impossible by construction.
REQ-018 Each cycle, if pending != 0 and FIFO not full (or full with same-cycle pop), the lowest set pending bit i SHALL be pushed as COVER_INDEX+i and cleared from pending.
REQ-019 At most one push and one pop per cycle; simultaneous push and pop on a full FIFO SHALL both succeed.
REQ-020 Reports for one batch of new hits SHALL emerge in ascending index order; no report is ever dropped or duplicated (pending bitmap absorbs backpressure).
REQ-021 Latency: valid[i] first high in cycle N with empty FIFO and pending -> out_valid high with out_index=COVER_INDEX+i in cycle N+2.
REQ-022 Handshake: pop iff out_valid && out_ready; out_valid/out_index SHALL stay stable while out_valid && !out_ready.
REQ-023 out_index is 0 whenever out_valid is low.
REQ-024 Pointers wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-025 A point hit repeatedly or in the same cycle as its report SHALL not be re-queued.
REQ-026 clear has priority over same-cycle valid, push and pop: hits in a clear cycle are discarded.

Reset
REQ-027 reset or clear SHALL zero hit_map, pending, FIFO pointers/count, hit_count; outputs next cycle: out_valid 0, out_index 0, hit_count 0, all_covered 0, busy 0.
REQ-028 reset asserted mid-drain SHALL discard all queued and pending reports without emitting them.

Structure
REQ-029 Shared package cover_pkg SHALL hold COVER_TOTAL, the 64-bit cover index type, and the lowest-set-bit encode function.
REQ-030 The report FIFO SHALL be sub-module cover_report_fifo (parameters DEPTH, 64-bit data, synchronous reset, valid/ready pop side).
REQ-031 Block SHALL be excluded from trace and from synthesis, matching other coverage monitors.

Verification
REQ-032 WIDTH=66, COVER_INDEX=100: valid[5] pulsed cycle 10, out_ready=1 -> out_valid cycle 12, out_index=105, hit_count=1.
REQ-033 valid=all ones one cycle, out_ready=1 -> 66 reports 100..165 ascending, one per cycle, then all_covered=1, busy=0.
REQ-034 DEPTH=4, out_ready=0, hits on bits 0..9 -> out_valid held with out_index=100, FIFO fills 4, pending holds 6; release out_ready -> 100..109 in order, none lost.
REQ-035 valid[3] held high 50 cycles, enable toggling -> exactly one report 103; with enable=0 throughout, none.
REQ-036 clear asserted while 3 reports queued and valid[7] high -> next cycle out_valid=0, hit_count=0, no report 107; valid[7] again after -> single report 107.
REQ-037 reset asserted during drain of REQ-033 -> all outputs at reset values next cycle, no further reports.

Source files
------------

// File: rtl/cover_pkg.sv
// Shared definitions for the toggle-coverage collectors.
//   COVER_TOTAL   : number of global toggle cover points in the design
//   MAX_WIDTH     : largest number of points one collector instance may own
//   cover_index_t : 64-bit global cover point index carried in reports
//   lowest_set()  : index of the lowest set bit of a MAX_WIDTH-bit vector
package cover_pkg;

    localparam int COVER_TOTAL = 38253;
    localparam int MAX_WIDTH   = 1024;
    localparam int IDX_BITS    = 11;

    typedef logic [63:0] cover_index_t;

    // Returns 0 for an all-zero vector; callers qualify the result with
    // their own "any bit set" term.
    function automatic logic [IDX_BITS-1:0] lowest_set(input logic [MAX_WIDTH-1:0] vec);
        logic [IDX_BITS-1:0] idx;
        idx = '0;
        // Scanning downwards lets the lowest set bit overwrite all others.
        for (int k = MAX_WIDTH - 1; k >= 0; k--) begin
            if (vec[k]) begin
                idx = IDX_BITS'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cover_report_fifo.sv
// Small report FIFO for cover point indices.
//   clk     : clock, all state on rising edge
//   srst    : synchronous active-high reset, empties the FIFO
//   i_push  : write request (ignored when full unless a pop happens too)
//   i_data  : 64-bit index to write
//   o_full  : FIFO holds DEPTH entries
//   o_valid : head entry present
//   i_ready : consumer takes the head when o_valid is high
//   o_data  : head entry, forced to zero while empty
module cover_report_fifo
    import cover_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         i_push,
    input  cover_index_t i_data,
    output logic         o_full,
    output logic         o_valid,
    input  logic         i_ready,
    output cover_index_t o_data
);

    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("cover_report_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    cover_index_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_valid = (r_count != '0);
    assign w_pop   = o_valid & i_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: o_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle coverage collector: records the first hit of each of WIDTH toggle
// cover points and reports it once, as a global index, through a
// valid/ready report FIFO. This is a simulation-side coverage monitor; the
// build keeps it out of synthesis and waveform trace like its siblings.
//   clock       : sole clock
//   reset       : synchronous active-high reset
//   valid       : per-point toggle-hit strobe
//   enable      : valid is ignored while low
//   clear       : synchronous coverage clear, same effect as reset
//   out_valid   : report head valid
//   out_ready   : consumer accepts head
//   out_index   : global index of head report (0 when out_valid is low)
//   hit_count   : distinct points hit since reset/clear
//   all_covered : every point has been hit
//   busy        : reports still pending or queued
module cover_toggle_collector
    import cover_pkg::*;
#(
    parameter int WIDTH       = 66,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = cover_pkg::COVER_TOTAL,
    parameter int DEPTH       = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             valid,
    input  logic                         enable,
    input  logic                         clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_index,
    output logic [$clog2(WIDTH+1)-1:0]   hit_count,
    output logic                         all_covered,
    output logic                         busy
);

    localparam int HCW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("cover_toggle_collector: WIDTH must be within 1..1024");
        end
        if (COVER_INDEX < 0 || COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
            $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
        end
    endgenerate

    logic [WIDTH-1:0]    r_hit_map;
    logic [WIDTH-1:0]    r_pending;
    logic [HCW-1:0]      r_hit_count;
    logic [WIDTH-1:0]    w_new_hits;
    logic [WIDTH-1:0]    w_take_mask;
    logic [IDX_BITS-1:0] w_low_idx;
    logic                w_any_pending;
    logic                w_fifo_full;
    logic                w_pop;
    logic                w_push;
    logic                w_srst;
    cover_index_t        w_push_index;

    assign w_srst        = reset | clear;
    // Only the first hit of a point since reset/clear counts; repeats are
    // masked by the hit map, so a point can never be queued twice.
    assign w_new_hits    = valid & ~r_hit_map & {WIDTH{enable}};
    assign w_any_pending = |r_pending;
    assign w_low_idx     = lowest_set(MAX_WIDTH'(r_pending));
    assign w_pop         = out_valid & out_ready;
    assign w_push        = w_any_pending & (~w_fifo_full | w_pop);
    assign w_push_index  = cover_index_t'(COVER_INDEX) + cover_index_t'(w_low_idx);

    // One-hot mask of the pending bit handed to the FIFO this cycle.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_take
            assign w_take_mask[gi] = w_push & (w_low_idx == IDX_BITS'(gi));
        end
    endgenerate

    // Pending bits only come from first hits, so a bit being taken this
    // cycle can never be re-set by a same-cycle strobe of that point.
    always_ff @(posedge clock) begin
        if (w_srst) begin
            r_hit_map   <= '0;
            r_pending   <= '0;
            r_hit_count <= '0;
        end else begin
            r_hit_map   <= r_hit_map | w_new_hits;
            r_pending   <= (r_pending | w_new_hits) & ~w_take_mask;
            r_hit_count <= r_hit_count + HCW'($countones(w_new_hits));
        end
    end

    cover_report_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .srst    (w_srst),
        .i_push  (w_push),
        .i_data  (w_push_index),
        .o_full  (w_fifo_full),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (out_index)
    );

    assign hit_count   = r_hit_count;
    assign all_covered = (r_hit_count == HCW'(WIDTH));
    assign busy        = w_any_pending | out_valid;

endmodule

// File: tb/tb_cover_toggle_collector.sv
module tb_cover_toggle_collector;

    localparam int WIDTH = 66;
    localparam int CI    = 100;
    localparam int DEPTH = 4;
    localparam int HCW   = $clog2(WIDTH + 1);

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] valid;
    logic             enable;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_index;
    logic [HCW-1:0]   hit_count;
    logic             all_covered;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int got[$];
    int got_cyc[$];

    always #5 clock = ~clock;

    cover_toggle_collector #(
        .WIDTH       (WIDTH),
        .COVER_INDEX (CI),
        .DEPTH       (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .valid       (valid),
        .enable      (enable),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .hit_count   (hit_count),
        .all_covered (all_covered),
        .busy        (busy)
    );

    // Reference model: a set of points already hit, a set of points hit but
    // not yet queued, and a bounded report queue. Each cycle the smallest
    // waiting point moves into the queue when there is room.
    bit [WIDTH-1:0] m_hit;
    bit [WIDTH-1:0] m_wait;
    int             m_q[$];
    int             m_cnt;
    int             m_lo;
    bit             m_pop;
    logic           e_valid;
    logic [63:0]    e_index;
    logic [HCW-1:0] e_count;
    logic           e_all;
    logic           e_busy;

    always @(posedge clock) begin
        cyc++;
        if (reset || clear) begin
            m_hit  = '0;
            m_wait = '0;
            m_q.delete();
            m_cnt  = 0;
        end else begin
            m_pop = (m_q.size() > 0) && out_ready;
            m_lo  = -1;
            for (int i = 0; i < WIDTH; i++) begin
                if (m_wait[i] && m_lo < 0) m_lo = i;
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (enable && valid[i] && !m_hit[i]) begin
                    m_hit[i]  = 1'b1;
                    m_wait[i] = 1'b1;
                    m_cnt++;
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_lo >= 0 && m_q.size() < DEPTH) begin
                m_q.push_back(m_lo);
                m_wait[m_lo] = 1'b0;
            end
        end
        e_valid = (m_q.size() > 0);
        e_index = 64'd0;
        if (m_q.size() > 0) e_index = 64'(CI + m_q[0]);
        e_count = HCW'(m_cnt);
        e_all   = (m_cnt == WIDTH);
        e_busy  = (m_wait != '0) || (m_q.size() > 0);
    end

    // Advance one cycle, logging any handshake completing at this edge.
    task automatic tick();
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got.push_back(int'(out_index));
            got_cyc.push_back(cyc);
            $display("report index=%0d cycle=%0d", out_index, cyc);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; enable = 1'b1; out_ready = 1'b1;
        valid = '1;
        tick();
        tick();
        reset = 1'b0;
        valid = '0;
        n_checks++;
        if ({out_valid, out_index, hit_count, all_covered, busy} !== {1'b0, 64'd0, HCW'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b idx=%0d cnt=%0d all=%0b busy=%0b, expected all zero",
                     out_valid, out_index, hit_count, all_covered, busy);
        end
    endtask

    task automatic test_single_hit();
        int base;
        apply_clear();
        out_ready = 1'b1;
        tick();
        base = got.size();
        valid[5] = 1'b1;
        tick();
        valid = '0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_n1: out_valid=%0b, expected 0 one cycle after hit", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 64'd105 || hit_count !== HCW'(1)) begin
            n_fail++;
            $display("FAIL single_n2: valid=%0b idx=%0d cnt=%0d, expected valid=1 idx=105 cnt=1",
                     out_valid, out_index, hit_count);
        end
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (got.size() != base + 1 || got[got.size()-1] != 105) begin
            n_fail++;
            $display("FAIL single_count: reports=%0d last=%0d, expected 1 report of 105",
                     got.size() - base, got.size() > 0 ? got[got.size()-1] : -1);
        end
    endtask

    task automatic test_all_ones();
        int base;
        int n;
        bit done;
        apply_clear();
        out_ready = 1'b1;
        base = got.size();
        valid = '1;
        tick();
        valid = '0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            n_checks++;
            if ({out_valid, out_index, hit_count, all_covered, busy} !== {e_valid, e_index, e_count, e_all, e_busy}) begin
                n_fail++;
                $display("FAIL all_ones_model: v=%0b idx=%0d cnt=%0d all=%0b busy=%0b, expected v=%0b idx=%0d cnt=%0d all=%0b busy=%0b",
                         out_valid, out_index, hit_count, all_covered, busy, e_valid, e_index, e_count, e_all, e_busy);
            end
            if (busy === 1'b0) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL all_ones_timeout: busy=%0b after 200 cycles, expected 0", busy);
        end
        n = got.size() - base;
        n_checks++;
        if (n != WIDTH) begin
            n_fail++;
            $display("FAIL all_ones_count: reports=%0d, expected %0d", n, WIDTH);
        end
        for (int k = 0; k < n && k < WIDTH; k++) begin
            n_checks++;
            if (got[base+k] != CI + k || (k > 0 && got_cyc[base+k] != got_cyc[base+k-1] + 1)) begin
                n_fail++;
                $display("FAIL all_ones_order: report %0d idx=%0d cycle=%0d, expected idx=%0d one cycle after previous",
                         k, got[base+k], got_cyc[base+k], CI + k);
            end
        end
        n_checks++;
        if (all_covered !== 1'b1 || busy !== 1'b0 || hit_count !== HCW'(WIDTH)) begin
            n_fail++;
            $display("FAIL all_ones_final: all=%0b busy=%0b cnt=%0d, expected all=1 busy=0 cnt=%0d",
                     all_covered, busy, hit_count, WIDTH);
        end
    endtask

    task automatic test_backpressure();
        int base;
        bit done;
        apply_clear();
        out_ready = 1'b0;
        base = got.size();
        valid[9:0] = '1;
        tick();
        valid = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_checks++;
            if ({out_valid, out_index, hit_count, all_covered, busy} !== {e_valid, e_index, e_count, e_all, e_busy}) begin
                n_fail++;
                $display("FAIL bp_model: v=%0b idx=%0d cnt=%0d busy=%0b, expected v=%0b idx=%0d cnt=%0d busy=%0b",
                         out_valid, out_index, hit_count, busy, e_valid, e_index, e_count, e_busy);
            end
            if (c >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_index !== 64'd100 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_hold: v=%0b idx=%0d busy=%0b, expected v=1 idx=100 busy=1",
                             out_valid, out_index, busy);
                end
            end
        end
        out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            n_checks++;
            if ({out_valid, out_index, busy} !== {e_valid, e_index, e_busy}) begin
                n_fail++;
                $display("FAIL bp_drain_model: v=%0b idx=%0d busy=%0b, expected v=%0b idx=%0d busy=%0b",
                         out_valid, out_index, busy, e_valid, e_index, e_busy);
            end
            if (busy === 1'b0) done = 1'b1;
        end
        n_checks++;
        if (got.size() - base != 10) begin
            n_fail++;
            $display("FAIL bp_count: reports=%0d, expected 10", got.size() - base);
        end
        for (int k = 0; k < 10 && base + k < got.size(); k++) begin
            n_checks++;
            if (got[base+k] != CI + k) begin
                n_fail++;
                $display("FAIL bp_order: report %0d idx=%0d, expected %0d", k, got[base+k], CI + k);
            end
        end
    endtask

    task automatic test_repeat_enable();
        int base;
        apply_clear();
        out_ready = 1'b1;
        base = got.size();
        valid[3] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            enable = (c % 7 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if ({out_valid, out_index, hit_count, busy} !== {e_valid, e_index, e_count, e_busy}) begin
                n_fail++;
                $display("FAIL repeat_model: v=%0b idx=%0d cnt=%0d busy=%0b, expected v=%0b idx=%0d cnt=%0d busy=%0b",
                         out_valid, out_index, hit_count, busy, e_valid, e_index, e_count, e_busy);
            end
        end
        valid = '0;
        enable = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        n_checks++;
        if (got.size() - base != 1 || got[got.size()-1] != 103) begin
            n_fail++;
            $display("FAIL repeat_once: reports=%0d, expected exactly one report 103", got.size() - base);
        end
        apply_clear();
        base = got.size();
        enable = 1'b0;
        valid[3] = 1'b1;
        for (int c = 0; c < 50; c++) tick();
        valid = '0;
        for (int c = 0; c < 3; c++) tick();
        enable = 1'b1;
        n_checks++;
        if (got.size() != base || hit_count !== HCW'(0) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_disabled: reports=%0d cnt=%0d busy=%0b, expected 0 0 0",
                     got.size() - base, hit_count, busy);
        end
    endtask

    task automatic test_clear_mid();
        int base;
        apply_clear();
        out_ready = 1'b0;
        base = got.size();
        valid[2:0] = '1;
        tick();
        valid = '0;
        for (int c = 0; c < 3; c++) tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== 64'd100 || hit_count !== HCW'(3)) begin
            n_fail++;
            $display("FAIL clear_pre: v=%0b idx=%0d cnt=%0d, expected v=1 idx=100 cnt=3",
                     out_valid, out_index, hit_count);
        end
        valid[7] = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        valid = '0;
        n_checks++;
        if ({out_valid, out_index, hit_count, all_covered, busy} !== {1'b0, 64'd0, HCW'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_after: v=%0b idx=%0d cnt=%0d all=%0b busy=%0b, expected all zero",
                     out_valid, out_index, hit_count, all_covered, busy);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        n_checks++;
        if (got.size() != base) begin
            n_fail++;
            $display("FAIL clear_discard: reports=%0d after clear, expected 0", got.size() - base);
        end
        valid[7] = 1'b1;
        tick();
        valid = '0;
        for (int c = 0; c < 5; c++) tick();
        n_checks++;
        if (got.size() - base != 1 || got[got.size()-1] != 107) begin
            n_fail++;
            $display("FAIL clear_rehit: reports=%0d, expected exactly one report 107", got.size() - base);
        end
    endtask

    task automatic test_reset_mid_drain();
        int base;
        apply_clear();
        out_ready = 1'b1;
        valid = '1;
        tick();
        valid = '0;
        for (int c = 0; c < 20; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({out_valid, out_index, hit_count, all_covered, busy} !== {1'b0, 64'd0, HCW'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_drain: v=%0b idx=%0d cnt=%0d all=%0b busy=%0b, expected all zero",
                     out_valid, out_index, hit_count, all_covered, busy);
        end
        base = got.size();
        for (int c = 0; c < 80; c++) tick();
        n_checks++;
        if (got.size() != base || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drain_quiet: reports=%0d busy=%0b, expected 0 reports busy=0",
                     got.size() - base, busy);
        end
    endtask

    task automatic test_random();
        apply_clear();
        for (int c = 0; c < 1500; c++) begin
            valid = '0;
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < 3; k++) valid[$urandom_range(0, WIDTH - 1)] = 1'b1;
            end
            enable    = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 149) == 0);
            tick();
            n_checks++;
            if ({out_valid, out_index, hit_count, all_covered, busy} !== {e_valid, e_index, e_count, e_all, e_busy}) begin
                n_fail++;
                $display("FAIL random_model: cycle=%0d v=%0b idx=%0d cnt=%0d all=%0b busy=%0b, expected v=%0b idx=%0d cnt=%0d all=%0b busy=%0b",
                         cyc, out_valid, out_index, hit_count, all_covered, busy, e_valid, e_index, e_count, e_all, e_busy);
            end
        end
        valid = '0; clear = 1'b0; enable = 1'b1; out_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; enable = 1'b1; out_ready = 1'b0; valid = '0;
        test_reset();
        test_single_hit();
        test_all_ones();
        test_backpressure();
        test_repeat_enable();
        test_clear_mid();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
